// File: rtl/warning_pkg.sv
// rtl/warning_pkg.sv - shared alert-state encoding and warning bit indices
package warning_pkg;

  localparam int NUM_WARN = 7;

  localparam int W_SEAT   = 0;
  localparam int W_DOOR   = 1;
  localparam int W_HOOD   = 2;
  localparam int W_TRUNK  = 3;
  localparam int W_BAT    = 4;
  localparam int W_AIRBAG = 5;
  localparam int W_TEMP   = 6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRI1  = 2'd1,
    ST_PRI2  = 2'd2,
    ST_MUTED = 2'd3
  } alert_state_t;

endpackage

// File: rtl/warn_display_rotator.sv
// rtl/warn_display_rotator.sv - time-multiplexes active warnings onto one display code
module warn_display_rotator
  import warning_pkg::*;
#(
  parameter int DWELL = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_WARN-1:0] warn_vec,
  input  logic                tick,
  output logic                disp_valid,
  output logic [2:0]          disp_code
);

  localparam int DW_W = $clog2(DWELL + 1);
  localparam logic [DW_W-1:0] DW_LAST = DW_W'(DWELL - 1);

  logic [2:0]          idx, idx_d;
  logic [DW_W-1:0]     dwell, dwell_d;
  logic                valid_d;
  logic [NUM_WARN-1:0] vec_prev, rise_above;

  // Next set bit strictly after 'from', wrapping; returns 'from' if it is the only one.
  function automatic logic [2:0] next_set(input logic [NUM_WARN-1:0] v, input logic [2:0] from);
    logic [2:0] r;
    r = from;
    for (int k = NUM_WARN; k >= 1; k--) begin
      if (v[(int'(from) + k) % NUM_WARN]) r = 3'((int'(from) + k) % NUM_WARN);
    end
    return r;
  endfunction

  function automatic logic [2:0] top_bit(input logic [NUM_WARN-1:0] v);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 0; i < NUM_WARN; i++) begin
      if (v[i]) r = 3'(i);
    end
    return r;
  endfunction

  always_comb begin
    for (int i = 0; i < NUM_WARN; i++) begin
      rise_above[i] = warn_vec[i] & ~vec_prev[i] & (~disp_valid | (i > int'(idx)));
    end
  end

  always_comb begin
    valid_d = disp_valid;
    idx_d   = idx;
    dwell_d = dwell;
    if (warn_vec == '0) begin
      valid_d = 1'b0;
      idx_d   = 3'd0;
      dwell_d = '0;
    end else if (rise_above != '0) begin
      valid_d = 1'b1;
      idx_d   = top_bit(rise_above);
      dwell_d = '0;
    end else if (!disp_valid) begin
      valid_d = 1'b1;
      idx_d   = top_bit(warn_vec);
      dwell_d = '0;
    end else if (!warn_vec[idx]) begin
      idx_d   = next_set(warn_vec, idx);
      dwell_d = '0;
    end else if (tick) begin
      if (dwell == DW_LAST) begin
        idx_d   = next_set(warn_vec, idx);
        dwell_d = '0;
      end else begin
        dwell_d = dwell + DW_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx        <= 3'd0;
      dwell      <= '0;
      vec_prev   <= '0;
      disp_valid <= 1'b0;
      disp_code  <= 3'd0;
    end else begin
      idx        <= idx_d;
      dwell      <= dwell_d;
      vec_prev   <= warn_vec;
      disp_valid <= valid_d;
      disp_code  <= valid_d ? (idx_d + 3'd1) : 3'd0;
    end
  end

endmodule

// File: rtl/warning_alert_sequencer.sv
// rtl/warning_alert_sequencer.sv - chime cadence FSM, mute handling and display rotation
// Optional: ALERT_LOG_EN adds the saturating pri1_count output.
module warning_alert_sequencer
  import warning_pkg::*;
#(
  parameter int TICK_DIV = 1000,
  parameter int P1_ON    = 2,
  parameter int P1_OFF   = 2,
  parameter int P2_ON    = 4,
  parameter int P2_OFF   = 12,
  parameter int P2_REPS  = 5,
  parameter int DWELL    = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                warn_pri1,
  input  logic                warn_pri2,
  input  logic [NUM_WARN-1:0] warn_vec,
  input  logic                mute_req,
  output logic                chime_out,
  output logic                disp_valid,
  output logic [2:0]          disp_code,
  output logic [1:0]          alert_state
`ifdef ALERT_LOG_EN
  ,
  output logic [7:0]          pri1_count
`endif
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PMAX    = PW'(TICK_DIV - 1);
  localparam logic [15:0]   P1_LAST = 16'(P1_ON + P1_OFF - 1);
  localparam logic [15:0]   P2_LAST = 16'(P2_ON + P2_OFF - 1);
  localparam logic [15:0]   P1_HI   = 16'(P1_ON);
  localparam logic [15:0]   P2_HI   = 16'(P2_ON);
  localparam logic [3:0]    B_LAST  = 4'(P2_REPS - 1);

  alert_state_t        state, state_d;
  logic [PW-1:0]       presc;
  logic                tick;
  logic [15:0]         phase, phase_d;
  logic [3:0]          burst, burst_d;
  logic                fresh, silence, chime_d;
  logic                mute_prev, mute_rise;
  logic [NUM_WARN-1:0] vec_prev;
  logic                vec_rise;

  assign tick        = (presc == PMAX);
  assign mute_rise   = mute_req & ~mute_prev;
  assign vec_rise    = |(warn_vec & ~vec_prev);
  assign alert_state = state;

  always_comb begin
    state_d = state;
    phase_d = phase;
    burst_d = burst;
    fresh   = 1'b0;
    silence = 1'b0;
    case (state)
      ST_IDLE: begin
        if (warn_pri1) begin
          state_d = ST_PRI1;
          fresh   = 1'b1;
        end else if (warn_pri2) begin
          state_d = ST_PRI2;
          fresh   = 1'b1;
        end
      end
      ST_PRI1: begin
        if (warn_pri1) begin
          if (tick) phase_d = (phase == P1_LAST) ? 16'd0 : phase + 16'd1;
        end else if (warn_pri2) begin
          state_d = ST_PRI2;
          fresh   = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PRI2: begin
        if (warn_pri1) begin
          state_d = ST_PRI1;
          fresh   = 1'b1;
        end else if (!warn_pri2) begin
          state_d = ST_IDLE;
        end else begin
          if (tick) begin
            if (phase == P2_LAST) begin
              phase_d = 16'd0;
              burst_d = burst + 4'd1;
              silence = (burst == B_LAST);
            end else begin
              phase_d = phase + 16'd1;
            end
          end
          if (mute_rise || silence) state_d = ST_MUTED;
        end
      end
      ST_MUTED: begin
        if (warn_pri1) begin
          state_d = ST_PRI1;
          fresh   = 1'b1;
        end else if (!warn_pri2) begin
          state_d = ST_IDLE;
        end else if (vec_rise) begin
          state_d = ST_PRI2;
          fresh   = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (fresh) begin
      phase_d = 16'd0;
      burst_d = 4'd0;
    end
    // Chime is registered from the next state so it moves on the same edge as alert_state.
    chime_d = ((state_d == ST_PRI1) && (phase_d < P1_HI)) ||
              ((state_d == ST_PRI2) && (phase_d < P2_HI));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      presc     <= '0;
      phase     <= 16'd0;
      burst     <= 4'd0;
      chime_out <= 1'b0;
      mute_prev <= 1'b0;
      vec_prev  <= '0;
    end else begin
      state     <= state_d;
      presc     <= tick ? '0 : presc + PW'(1);
      phase     <= phase_d;
      burst     <= burst_d;
      chime_out <= chime_d;
      mute_prev <= mute_req;
      vec_prev  <= warn_vec;
    end
  end

`ifdef ALERT_LOG_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pri1_count <= 8'd0;
    end else if ((state != ST_PRI1) && (state_d == ST_PRI1) && (pri1_count != 8'hFF)) begin
      pri1_count <= pri1_count + 8'd1;
    end
  end
`endif

  warn_display_rotator #(
    .DWELL(DWELL)
  ) u_rotator (
    .clk       (clk),
    .rst_n     (rst_n),
    .warn_vec  (warn_vec),
    .tick      (tick),
    .disp_valid(disp_valid),
    .disp_code (disp_code)
  );

endmodule
